// File: rtl/riscv_irq_ctrl.sv
// Memory-mapped machine timer (64-bit mtime/mtimecmp with prescaler) and
// edge-triggered external interrupt controller producing single-cycle irq pulses.
module riscv_irq_ctrl #(
   parameter logic [31:0] BASE        = 32'h0200_0000,
   parameter int          NSRC        = 8,
   parameter int          SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [31:0]     addr,
   input  logic [2:0]      mem_op,
   input  logic [31:0]     wdata,
   output logic [31:0]     rdata,
   output logic            sel,
   input  logic [NSRC-1:0] irq_src,
   output logic            timer_irq,
   output logic            hardware_irq
);

   localparam logic [5:0] OFF_MTIME_LO    = 6'h00;
   localparam logic [5:0] OFF_MTIME_HI    = 6'h01;
   localparam logic [5:0] OFF_MTIMECMP_LO = 6'h02;
   localparam logic [5:0] OFF_MTIMECMP_HI = 6'h03;
   localparam logic [5:0] OFF_PRESCALE    = 6'h04;
   localparam logic [5:0] OFF_PENDING     = 6'h05;
   localparam logic [5:0] OFF_ENABLE      = 6'h06;
   localparam logic [5:0] OFF_CLAIM       = 6'h07;

   logic [63:0]     r_mtime;
   logic [63:0]     r_mtimecmp;
   logic [15:0]     r_prescale;
   logic [15:0]     r_presc_cnt;
   logic            r_ge_q;
   logic            r_timer_irq;
   logic [NSRC-1:0] r_sync [SYNC_STAGES];
   logic [NSRC-1:0] r_src_q;
   logic [NSRC-1:0] r_pending;
   logic [NSRC-1:0] r_enable;
   logic [NSRC-1:0] r_pe_q;
   logic            r_hw_irq;

   logic [5:0]      w_word;
   logic            w_wr;
   logic            w_tick;
   logic            w_ge;
   logic [NSRC-1:0] w_rise;
   logic [NSRC-1:0] w_pe;
   logic            w_complete;
   logic [NSRC-1:0] w_cmpl_mask;
   logic [NSRC-1:0] w_clr;
   logic [NSRC-1:0] w_pending_nxt;
   logic [NSRC-1:0] w_enable_nxt;
   logic [4:0]      w_claim_id;
   logic            w_unused;

   assign sel      = (addr[31:8] == BASE[31:8]);
   assign w_word   = addr[7:2];
   // Only full-word stores modify state; byte/half stores are dropped.
   assign w_wr     = sel && (mem_op == 3'b111);
   assign w_unused = &{1'b0, addr[1:0]};

   assign w_tick = (r_presc_cnt == r_prescale);
   assign w_ge   = (r_mtime >= r_mtimecmp);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prescale  <= '0;
         r_presc_cnt <= '0;
      end else if (w_wr && w_word == OFF_PRESCALE) begin
         r_prescale  <= wdata[15:0];
         r_presc_cnt <= '0;
      end else if (w_tick) begin
         r_presc_cnt <= '0;
      end else begin
         r_presc_cnt <= r_presc_cnt + 16'd1;
      end
   end

   // A software write to either half wins over the tick and leaves the other half alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mtime <= '0;
      end else if (w_wr && w_word == OFF_MTIME_LO) begin
         r_mtime[31:0] <= wdata;
      end else if (w_wr && w_word == OFF_MTIME_HI) begin
         r_mtime[63:32] <= wdata;
      end else if (w_tick) begin
         r_mtime <= r_mtime + 64'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mtimecmp <= '1;
      end else if (w_wr && w_word == OFF_MTIMECMP_LO) begin
         r_mtimecmp[31:0] <= wdata;
      end else if (w_wr && w_word == OFF_MTIMECMP_HI) begin
         r_mtimecmp[63:32] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ge_q      <= 1'b0;
         r_timer_irq <= 1'b0;
      end else begin
         r_ge_q      <= w_ge;
         r_timer_irq <= w_ge & ~r_ge_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
         r_src_q <= '0;
      end else begin
         r_sync[0] <= irq_src;
         for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
         r_src_q <= r_sync[SYNC_STAGES-1];
      end
   end

   assign w_rise     = r_sync[SYNC_STAGES-1] & ~r_src_q;
   assign w_pe       = r_pending & r_enable;
   assign w_complete = w_wr && (w_word == OFF_CLAIM) && (wdata != 32'd0) && (wdata <= 32'(NSRC));

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      w_cmpl_mask = '0;
      for (int i = 0; i < NSRC; i++) w_cmpl_mask[i] = w_complete && (wdata == 32'(i + 1));
   end

   always_comb begin
      w_claim_id = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (w_pe[i]) w_claim_id = 5'(i + 1);
      end
   end

   // A same-cycle rising edge re-sets a bit even when software clears it.
   assign w_clr         = ((w_wr && w_word == OFF_PENDING) ? wdata[NSRC-1:0] : '0) | w_cmpl_mask;
   assign w_pending_nxt = (r_pending & ~w_clr) | w_rise;
   assign w_enable_nxt  = (w_wr && w_word == OFF_ENABLE) ? wdata[NSRC-1:0] : r_enable;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= '0;
         r_enable  <= '0;
         r_pe_q    <= '0;
         r_hw_irq  <= 1'b0;
      end else begin
         r_pending <= w_pending_nxt;
         r_enable  <= w_enable_nxt;
         r_pe_q    <= w_pe;
         r_hw_irq  <= (|(w_pe & ~r_pe_q)) | (w_complete && |(w_pending_nxt & w_enable_nxt));
      end
   end

   assign timer_irq    = r_timer_irq;
   assign hardware_irq = r_hw_irq;

   always_comb begin
      rdata = '0;
      if (sel) begin
         case (w_word)
            OFF_MTIME_LO:    rdata = r_mtime[31:0];
            OFF_MTIME_HI:    rdata = r_mtime[63:32];
            OFF_MTIMECMP_LO: rdata = r_mtimecmp[31:0];
            OFF_MTIMECMP_HI: rdata = r_mtimecmp[63:32];
            OFF_PRESCALE:    rdata = {16'd0, r_prescale};
            OFF_PENDING:     rdata = 32'(r_pending);
            OFF_ENABLE:      rdata = 32'(r_enable);
            OFF_CLAIM:       rdata = 32'(w_claim_id);
            default:         rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_irq_ctrl.sv
// Scoreboard bench for riscv_irq_ctrl: stimulus queues expected reads and irq
// pulse cycles; a negedge monitor pops and compares whenever the DUT responds.
module tb_riscv_irq_ctrl;

   localparam logic [31:0] BASE = 32'h0200_0000;
   localparam int          NSRC = 8;

   localparam logic [7:0] A_MTIME_LO    = 8'h00;
   localparam logic [7:0] A_MTIME_HI    = 8'h04;
   localparam logic [7:0] A_MTIMECMP_LO = 8'h08;
   localparam logic [7:0] A_MTIMECMP_HI = 8'h0C;
   localparam logic [7:0] A_PRESCALE    = 8'h10;
   localparam logic [7:0] A_PENDING     = 8'h14;
   localparam logic [7:0] A_ENABLE      = 8'h18;
   localparam logic [7:0] A_CLAIM       = 8'h1C;

   typedef struct {
      logic [31:0] data;
      logic        exp_sel;
      string       name;
   } rd_exp_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [31:0]     addr;
   logic [2:0]      mem_op;
   logic [31:0]     wdata;
   logic [31:0]     rdata;
   logic            sel;
   logic [NSRC-1:0] irq_src;
   logic            timer_irq;
   logic            hardware_irq;

   int unsigned cyc = 0;
   int          checks = 0;
   int          failures = 0;
   bit          mon_en = 1'b0;
   int unsigned v;

   rd_exp_t     rd_q[$];
   int unsigned timer_q[$];
   int unsigned hw_q[$];

   riscv_irq_ctrl #(.BASE(BASE), .NSRC(NSRC), .SYNC_STAGES(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .addr         (addr),
      .mem_op       (mem_op),
      .wdata        (wdata),
      .rdata        (rdata),
      .sel          (sel),
      .irq_src      (irq_src),
      .timer_irq    (timer_irq),
      .hardware_irq (hardware_irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [2:0] op = 3'b111);
      addr   = BASE | 32'(off);
      mem_op = op;
      wdata  = d;
      step(1);
      mem_op = 3'b000;
   endtask

   task automatic rd_at(input logic [31:0] a, input logic [31:0] exp, input logic exp_sel,
                        input string name, input logic [2:0] op = 3'b011);
      rd_exp_t e;
      e.data = exp; e.exp_sel = exp_sel; e.name = name;
      rd_q.push_back(e);
      addr   = a;
      mem_op = op;
      step(1);
      mem_op = 3'b000;
   endtask

   task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string name);
      rd_at(BASE | 32'(off), exp, 1'b1, name);
   endtask

   task automatic src_pulse(input int i);
      irq_src[i] = 1'b1;
      step(2);
      irq_src[i] = 1'b0;
   endtask

   // Monitor: compares loads, and every irq pulse against the queued expected cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         if (mem_op[1:0] != 2'b00 && !mem_op[2]) begin
            if (rd_q.size() == 0) begin
               check("unexpected_load", 64'(rd_q.size()), 64'd1);
            end else begin
               rd_exp_t e;
               e = rd_q.pop_front();
               check({e.name, "_sel"}, 64'(sel), 64'(e.exp_sel));
               if (e.exp_sel) check(e.name, 64'(rdata), 64'(e.data));
            end
         end
         if (timer_irq) begin
            if (timer_q.size() == 0) check("timer_irq_unexpected", 64'(timer_irq), 64'd0);
            else check("timer_irq_cycle", 64'(cyc), 64'(timer_q.pop_front()));
         end
         if (hardware_irq) begin
            if (hw_q.size() == 0) check("hw_irq_unexpected", 64'(hardware_irq), 64'd0);
            else check("hw_irq_cycle", 64'(cyc), 64'(hw_q.pop_front()));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      addr = '0; mem_op = 3'b000; wdata = '0; irq_src = '0;
      step(3);
      mon_en = 1'b1;
      rst_n  = 1'b1;

      // Reset state; a byte-size load still returns the full word.
      rd_at(BASE | 32'(A_MTIMECMP_LO), 32'hFFFF_FFFF, 1'b1, "rst_mtimecmp_lo_byte", 3'b001);
      rd(A_MTIMECMP_HI, 32'hFFFF_FFFF, "rst_mtimecmp_hi");
      rd(A_PRESCALE,    32'h0,         "rst_prescale");
      rd(A_PENDING,     32'h0,         "rst_pending");
      rd(A_ENABLE,      32'h0,         "rst_enable");
      rd(A_CLAIM,       32'h0,         "rst_claim");

      // Prescaled counting and a single timer pulse one cycle after mtime hits 5.
      wr(A_PRESCALE,    32'd3);
      wr(A_MTIME_LO,    32'd0);
      wr(A_MTIME_HI,    32'd0);
      wr(A_MTIMECMP_HI, 32'd0);
      wr(A_MTIMECMP_LO, 32'd5);
      timer_q.push_back(cyc + 17);
      rd(A_MTIME_LO, 32'd1, "presc_mtime_first");
      step(20);
      rd(A_MTIME_LO, 32'd6, "presc_mtime_later");
      wr(A_MTIMECMP_HI, 32'hFFFF_FFFF);

      // Carry from low to high half, and write priority over a tick.
      wr(A_PRESCALE, 32'd0);
      wr(A_MTIME_HI, 32'd0);
      wr(A_MTIME_LO, 32'hFFFF_FFFF);
      rd(A_MTIME_LO, 32'hFFFF_FFFF, "carry_lo_written");
      rd(A_MTIME_HI, 32'd1,         "carry_hi");
      rd(A_MTIME_LO, 32'd1,         "carry_lo_after");
      wr(A_MTIME_LO, 32'd7);
      rd(A_MTIME_LO, 32'd7,         "write_beats_tick");
      rd(A_MTIME_HI, 32'd1,         "write_no_carry_hi");

      // Two enabled sources, claim and complete.
      wr(A_ENABLE, 32'h05);
      v = cyc; hw_q.push_back(v + 4);
      src_pulse(2); step(4);
      v = cyc; hw_q.push_back(v + 4);
      src_pulse(0); step(4);
      rd(A_PENDING, 32'h05, "pending_two");
      rd(A_CLAIM,   32'd1,  "claim_first");
      v = cyc; hw_q.push_back(v + 1);
      wr(A_CLAIM, 32'd1);
      rd(A_CLAIM, 32'd3, "claim_second");
      wr(A_CLAIM, 32'd9);
      wr(A_CLAIM, 32'd0);
      rd(A_CLAIM, 32'd3, "claim_bad_id_ignored");
      wr(A_CLAIM, 32'd3);
      rd(A_CLAIM, 32'd0, "claim_none");
      step(3);

      // Pending while disabled; enabling later exposes it.
      wr(A_ENABLE, 32'h00);
      src_pulse(1); step(4);
      rd(A_PENDING, 32'h02, "pending_disabled");
      v = cyc; hw_q.push_back(v + 2);
      wr(A_ENABLE, 32'h02);
      step(3);

      // Set beats a same-cycle W1C clear.
      wr(A_PENDING, 32'h02);
      v = cyc; hw_q.push_back(v + 4);
      irq_src[1] = 1'b1;
      step(2);
      wr(A_PENDING, 32'h02);
      rd(A_PENDING, 32'h02, "set_beats_clear");
      irq_src[1] = 1'b0;
      step(3);

      // Narrow stores are ignored; unmapped and out-of-window accesses.
      wr(A_ENABLE, 32'hFF, 3'b101);
      wr(A_ENABLE, 32'hFF, 3'b110);
      rd(A_ENABLE, 32'h02, "narrow_store_ignored");
      wr(8'h20, 32'hDEAD_BEEF);
      rd(8'h20, 32'h0, "unmapped_reads_zero");
      rd_at(32'h0300_0014, 32'h0, 1'b0, "out_of_window");

      // Asynchronous reset lands during a hardware_irq pulse.
      wr(A_PENDING, 32'h02);
      wr(A_PRESCALE, 32'd3);
      step(4);
      src_pulse(1);
      step(2);
      rst_n = 1'b0;
      #1;
      check("hw_irq_async_reset",    64'(hardware_irq), 64'd0);
      check("timer_irq_async_reset", 64'(timer_irq),    64'd0);
      rd(A_PENDING,     32'h0,         "reset_pending");
      rd(A_MTIME_LO,    32'h0,         "reset_mtime_lo");
      rd(A_MTIMECMP_HI, 32'hFFFF_FFFF, "reset_mtimecmp_hi");
      rd(A_ENABLE,      32'h0,         "reset_enable");
      rd(A_PRESCALE,    32'h0,         "reset_prescale");
      rst_n = 1'b1;
      step(3);
      rd(A_MTIME_LO, 32'd3, "post_reset_count");
      step(6);

      check("rd_q_drained",    64'(rd_q.size()),    64'd0);
      check("timer_q_drained", 64'(timer_q.size()), 64'd0);
      check("hw_q_drained",    64'(hw_q.size()),    64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
